// File: rtl/vga_sprite_disp.sv
// rtl/vga_sprite_disp.sv - VGA scan generator with one ROM image overlay, 1x/2x scale
// Optional: define VGA_COLORKEY_EN to make KEY_565 pixels transparent (show BG_RGB).
module vga_sprite_disp #(
  parameter int          H_SYNC   = 44,
  parameter int          H_BACK   = 148,
  parameter int          H_ACTIVE = 1920,
  parameter int          H_FRONT  = 88,
  parameter int          V_SYNC   = 5,
  parameter int          V_BACK   = 36,
  parameter int          V_ACTIVE = 1080,
  parameter int          V_FRONT  = 4,
  parameter int          IMG_W    = 200,
  parameter int          IMG_H    = 200,
  parameter int          ADDR_W   = 16,
  parameter int          ROM_LAT  = 1,
  parameter logic [11:0] BG_RGB   = 12'h000,
  parameter logic [15:0] KEY_565  = 16'hF81F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [11:0]       x_pos,
  input  logic [10:0]       y_pos,
  input  logic              scale2x,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [15:0]       rom_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0     = H_SYNC + H_BACK;
  localparam int VA0     = V_SYNC + V_BACK;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           started;
  logic           h_last, v_last;

  assign h_last      = (hcnt == HCW'(H_TOTAL - 1));
  assign v_last      = (vcnt == VCW'(V_TOTAL - 1));
  assign frame_start = started && (hcnt == '0) && (vcnt == '0);

  // Counters hold at 0 for one clock after reset so that clock is the frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else if (!started) begin
      started <= 1'b1;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  logic        en_sh, s2_sh;
  logic [11:0] x_sh;
  logic [10:0] y_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sh <= 1'b0;
      s2_sh <= 1'b0;
      x_sh  <= '0;
      y_sh  <= '0;
    end else if (frame_start) begin
      en_sh <= en;
      s2_sh <= scale2x;
      x_sh  <= x_pos;
      y_sh  <= y_pos;
    end
  end

  logic [15:0] h16, v16, x_lo, y_lo, img_w_s, img_h_s;
  logic        h_act, v_act, y_win, in_win;

  assign h16     = 16'(hcnt);
  assign v16     = 16'(vcnt);
  assign x_lo    = 16'(HA0) + 16'(x_sh);
  assign y_lo    = 16'(VA0) + 16'(y_sh);
  assign img_w_s = s2_sh ? 16'(2 * IMG_W) : 16'(IMG_W);
  assign img_h_s = s2_sh ? 16'(2 * IMG_H) : 16'(IMG_H);
  assign h_act   = (h16 >= 16'(HA0)) && (h16 < 16'(HA0 + H_ACTIVE));
  assign v_act   = (v16 >= 16'(VA0)) && (v16 < 16'(VA0 + V_ACTIVE));
  assign y_win   = v_act && (v16 >= y_lo) && (v16 < y_lo + img_h_s);
  assign in_win  = started && en_sh && h_act && y_win &&
                   (h16 >= x_lo) && (h16 < x_lo + img_w_s);

  logic [ADDR_W-1:0] line_base, sx;
  logic              xph, yph;

  // Source position is stepped incrementally; the phase bits repeat each source pixel in 2x mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
      sx        <= '0;
      xph       <= 1'b0;
      yph       <= 1'b0;
    end else begin
      if (frame_start) begin
        line_base <= '0;
        yph       <= 1'b0;
      end else if (h_last && y_win) begin
        if (!s2_sh || yph) begin
          line_base <= line_base + ADDR_W'(IMG_W);
          yph       <= 1'b0;
        end else begin
          yph <= 1'b1;
        end
      end
      if (h_last) begin
        sx  <= '0;
        xph <= 1'b0;
      end else if (in_win) begin
        if (!s2_sh || xph) begin
          sx  <= sx + 1'b1;
          xph <= 1'b0;
        end else begin
          xph <= 1'b1;
        end
      end
    end
  end

  // Delay lines: bit 0 is stage 1, bit ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0] hs_p, vs_p, de_p, win_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      rom_en   <= 1'b0;
      hs_p     <= '0;
      vs_p     <= '0;
      de_p     <= '0;
      win_p    <= '0;
    end else begin
      rom_addr <= in_win ? line_base + sx : '0;
      rom_en   <= in_win;
      hs_p     <= {hs_p[ROM_LAT-1:0], started && (hcnt < HCW'(H_SYNC))};
      vs_p     <= {vs_p[ROM_LAT-1:0], started && (vcnt < VCW'(V_SYNC))};
      de_p     <= {de_p[ROM_LAT-1:0], started && h_act && v_act};
      win_p    <= {win_p[ROM_LAT-1:0], in_win};
    end
  end

  logic key_hit;
`ifdef VGA_COLORKEY_EN
  assign key_hit = (rom_data == KEY_565);
`else
  assign key_hit = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{rom_data[11], rom_data[6:5], rom_data[0], KEY_565};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
    end else begin
      hsync <= ~hs_p[ROM_LAT];
      vsync <= ~vs_p[ROM_LAT];
      de    <= de_p[ROM_LAT];
      if (!de_p[ROM_LAT])
        {red, green, blue} <= '0;
      else if (win_p[ROM_LAT] && !key_hit)
        {red, green, blue} <= {rom_data[15:12], rom_data[10:7], rom_data[4:1]};
      else
        {red, green, blue} <= BG_RGB;
    end
  end

endmodule
